data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder (slave) end of the CPU data-memory load/store interface.
- Accepts single-word lw/sw requests from the pipeline or multi-cycle core through a valid/ready handshake.
- Applies a programmable access latency, commits stores with byte enables, and returns load data through a valid/ready response channel.
- Owns the data RAM array `mem`. Benches preload it with `$readmemh` into `dut.mem`.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words in `mem`.
- LATENCY, 2, wait cycles between request acceptance and response (legal 0..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store (sw), 0 = load (lw).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables; bit i enables byte lane [8i+7:8i].
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  32  load data; 0 for stores and for errors.
- resp_err  out  1  request was misaligned or out of range.

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready=1, because req_ready = (state==IDLE).
  - `mem` contents are NOT cleared, so preloads survive reset.
- Accept:
  - A request is accepted on a rising edge with req_valid && req_ready.
  - we/addr/wdata/be are latched at that edge. Later changes on req_* are ignored.
- IDLE -> WAIT on acceptance when LATENCY>0; counter loads LATENCY-1.
- IDLE -> RESP directly on acceptance when LATENCY==0.
- WAIT:
  - Counter decrements each cycle.
  - At counter==0 the next edge is the commit edge, and the state goes to RESP.
- Commit edge (the edge entering RESP):
  - Store: writes enabled bytes of wdata to mem[addr[31:2]].
  - Load: resp_rdata is sampled from mem[addr[31:2]].
  - resp_err is computed; resp_valid rises.
  - Response therefore appears LATENCY+1 cycles after the accept edge.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until resp_valid && resp_ready on an edge.
  - On that edge: state -> IDLE and resp_valid=0. resp_rdata/resp_err hold their last values.
  - req_ready=0 in WAIT and RESP. There is no back-to-back accept in the RESP-exit cycle; one idle cycle minimum between transactions.
- Error:
  - resp_err=1 if addr[1:0]!=0 or addr[31:2]>=MEM_DEPTH.
  - On error: no memory write occurs and resp_rdata=0.
- Stores:
  - resp_rdata=0.
  - be=4'b0000 is a legal no-op store that still returns a response.
- Ordering: a load issued after a completed store to the same word returns the stored value; no hazard is possible with one outstanding transaction.
- Reset mid-operation:
  - Asserting reset in WAIT aborts the transaction with no write.
  - Asserting reset in RESP drops the response; the committed store stays in memory.
- Out-of-range LATENCY (>15): elaboration error via `$error` in an initial/generate check.

Optional Feature:
- Macro: DMEM_ERR_CHECK_EN.
- Defined:
  - Alignment and range checking exactly as in Behaviour.
- Undefined:
  - resp_err is tied to 0.
  - addr[1:0] is ignored.
  - Word index = addr[31:2] modulo MEM_DEPTH (wraps), so every request performs its access.

Test Plan:
- Preload mem[4]=32'h1234, LATENCY=2. Load addr 0x10 -> resp_valid rises 3 cycles after accept, resp_rdata=32'h1234, resp_err=0, req_ready=0 throughout.
- Store 0x20 wdata=32'hDEADBEEF be=4'b0101, then load 0x20 (mem[8] was 0) -> resp_rdata=32'h00AD00EF.
- LATENCY=0: store 0x0 32'h0000000A be=4'hF, then load 0x0 -> response 1 cycle after each accept, rdata=32'h0000000A.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/resp_rdata stable, req_valid with new request not accepted. Raise resp_ready -> IDLE next edge.
- With DMEM_ERR_CHECK_EN: load 0x13 -> resp_err=1, rdata=0. Store to 0x1000 (MEM_DEPTH=1024) -> resp_err=1, mem[0] unchanged. Without the macro the same store overwrites mem[0].
- Assert reset during WAIT of a store to 0x30 -> after release req_ready=1, resp_valid=0, a subsequent load of 0x30 returns the old value.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: a single outstanding lw/sw with programmable latency and byte enables.
// Define DMEM_ERR_CHECK_EN to flag misaligned/out-of-range requests; otherwise the index wraps.
module data_mem_responder #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam bit          ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  if (LATENCY > 15) begin : g_latency_check
    $error("data_mem_responder: LATENCY must be in 0..15");
  end

  logic [31:0] mem [MEM_DEPTH];

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_resp_valid;
  logic [31:0] r_rdata;
  logic        r_err;

  logic          w_accept;
  logic          w_commit;
  logic          w_we;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [3:0]    w_be;
  logic [29:0]   w_word;
  logic          w_err;
  logic [AW-1:0] w_idx;

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  assign w_accept = req_valid && (r_state == IDLE);
  assign w_commit = (ZERO_LAT && w_accept) || ((r_state == WAIT) && (r_cnt == 4'd0));

  // With zero latency the commit happens on the accept edge, so use the live request.
  assign w_we    = (r_state == IDLE) ? req_we    : r_we;
  assign w_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_be    = (r_state == IDLE) ? req_be    : r_be;
  assign w_word  = w_addr[31:2];

`ifdef DMEM_ERR_CHECK_EN
  always_comb begin
    w_err = (w_addr[1:0] != 2'b00) || ({2'b00, w_word} >= 32'(MEM_DEPTH));
    w_idx = AW'(w_word);
  end
`else
  logic w_unused_addr_lsb;
  assign w_unused_addr_lsb = ^w_addr[1:0];

  always_comb begin
    w_err = 1'b0;
    w_idx = AW'({2'b00, w_word} % 32'(MEM_DEPTH));
  end
`endif

  // No reset on the array so preloaded contents survive reset.
  always_ff @(posedge clk) begin
    if (reset && w_commit && w_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_be         <= 4'd0;
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'd0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
            if (!ZERO_LAT) begin
              r_state <= WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_commit) begin
        r_state      <= RESP;
        r_resp_valid <= 1'b1;
        r_err        <= w_err;
        r_rdata      <= (w_we || w_err) ? 32'd0 : mem[w_idx];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: unit 0 has LATENCY=2, unit 1 has LATENCY=0; both are checked
// against a word-array model driven by random and directed load/store traffic.
module tb_data_mem_responder;

  localparam int unsigned Depth = 1024;
`ifdef DMEM_ERR_CHECK_EN
  localparam bit ErrChk = 1'b1;
`else
  localparam bit ErrChk = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_be     [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  logic [31:0] mdl   [2][Depth];
  bit          known [2][Depth];

  int vectors     = 0;
  int miscompares = 0;

  data_mem_responder #(.MEM_DEPTH(Depth), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_mem_responder #(.MEM_DEPTH(Depth), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  function automatic int lat_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  // Reference: a plain word array updated by the load/store/error rules.
  task automatic model_txn(input int u, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           output logic [31:0] er, output logic ee, output bit ek);
    int unsigned word;
    int unsigned idx;
    word = addr >> 2;
    ee   = ErrChk && (((addr % 4) != 0) || (word >= Depth));
    idx  = word % Depth;
    er   = 32'd0;
    ek   = 1'b1;
    if (!ee) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mdl[u][idx][8*i +: 8] = wdata[8*i +: 8];
        end
        if (be == 4'hF) known[u][idx] = 1'b1;
      end else begin
        er = mdl[u][idx];
        ek = known[u][idx];
      end
    end
  endtask

  task automatic issue(input int u, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    @(negedge clk);
    req_we[u]    = we;
    req_addr[u]  = addr;
    req_wdata[u] = wdata;
    req_be[u]    = be;
    req_valid[u] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[u] = 1'b0;
    req_we[u]    = 1'($urandom);
    req_addr[u]  = $urandom;
    req_wdata[u] = $urandom;
    req_be[u]    = 4'($urandom);
  endtask

  // Full transaction; lat counts the accept cycle as 1. proto flags any handshake violation.
  task automatic txn(input int u, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int hold,
                     output logic [31:0] rdata, output logic err, output int lat,
                     output bit proto);
    proto = 1'b1;
    issue(u, we, addr, wdata, be);
    lat = 1;
    while (resp_valid[u] !== 1'b1 && lat < 40) begin
      if (req_ready[u] !== 1'b0) proto = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    rdata = resp_rdata[u];
    err   = resp_err[u];
    if (req_ready[u] !== 1'b0) proto = 1'b0;
    for (int h = 0; h < hold; h++) begin
      req_valid[u] = 1'b1;
      @(posedge clk);
      #1;
      if (resp_valid[u] !== 1'b1 || resp_rdata[u] !== rdata || resp_err[u] !== err ||
          req_ready[u] !== 1'b0) proto = 1'b0;
    end
    req_valid[u]  = 1'b0;
    resp_ready[u] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[u] = 1'b0;
    if (resp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1 || resp_rdata[u] !== rdata ||
        resp_err[u] !== err) proto = 1'b0;
  endtask

  task automatic op(input int u, input logic we, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic [3:0] be, input int hold,
                    output logic [31:0] rdata, output logic err, output int lat,
                    output bit proto, output logic [31:0] er, output logic ee, output bit ek);
    model_txn(u, we, addr, wdata, be, er, ee, ek);
    txn(u, we, addr, wdata, be, hold, rdata, err, lat, proto);
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      vectors += 4;
      if (req_ready[u] !== 1'b1) begin
        $display("FAIL reset_req_ready u%0d: got %b want 1", u, req_ready[u]); miscompares++;
      end
      if (resp_valid[u] !== 1'b0) begin
        $display("FAIL reset_resp_valid u%0d: got %b want 0", u, resp_valid[u]); miscompares++;
      end
      if (resp_rdata[u] !== 32'd0) begin
        $display("FAIL reset_rdata u%0d: got %h want 0", u, resp_rdata[u]); miscompares++;
      end
      if (resp_err[u] !== 1'b0) begin
        $display("FAIL reset_err u%0d: got %b want 0", u, resp_err[u]); miscompares++;
      end
    end
  endtask

  task automatic test_load_basic();
    logic [31:0] rd, er; logic e, ee; int lat; bit pr, ek;
    op(0, 1'b1, 32'h10, 32'h1234, 4'hF, 0, rd, e, lat, pr, er, ee, ek);
    vectors += 2;
    if (rd !== 32'd0 || e !== 1'b0) begin
      $display("FAIL store_resp: got rdata %h err %b want 0 0", rd, e); miscompares++;
    end
    if (lat !== 3) begin
      $display("FAIL store_latency: got %0d want 3", lat); miscompares++;
    end
    op(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, rd, e, lat, pr, er, ee, ek);
    vectors += 4;
    if (lat !== 3) begin
      $display("FAIL load_latency: got %0d want 3", lat); miscompares++;
    end
    if (rd !== 32'h1234) begin
      $display("FAIL load_rdata: got %h want 00001234", rd); miscompares++;
    end
    if (e !== 1'b0) begin
      $display("FAIL load_err: got %b want 0", e); miscompares++;
    end
    if (pr !== 1'b1) begin
      $display("FAIL load_protocol: got %b want 1", pr); miscompares++;
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd, er; logic e, ee; int lat; bit pr, ek;
    op(0, 1'b1, 32'h20, 32'h0, 4'hF, 0, rd, e, lat, pr, er, ee, ek);
    op(0, 1'b1, 32'h20, 32'hDEADBEEF, 4'b0101, 0, rd, e, lat, pr, er, ee, ek);
    op(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, e, lat, pr, er, ee, ek);
    vectors++;
    if (rd !== 32'h00AD00EF) begin
      $display("FAIL byte_enable: got %h want 00ad00ef", rd); miscompares++;
    end
    op(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, rd, e, lat, pr, er, ee, ek);
    vectors++;
    if (lat !== 3 || e !== 1'b0) begin
      $display("FAIL be0_store_resp: got lat %0d err %b want 3 0", lat, e); miscompares++;
    end
    op(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, e, lat, pr, er, ee, ek);
    vectors++;
    if (rd !== 32'h00AD00EF) begin
      $display("FAIL be0_noop: got %h want 00ad00ef", rd); miscompares++;
    end
  endtask

  task automatic test_latency0();
    logic [31:0] rd, er; logic e, ee; int lat; bit pr, ek;
    op(1, 1'b1, 32'h0, 32'h0000000A, 4'hF, 0, rd, e, lat, pr, er, ee, ek);
    vectors++;
    if (lat !== 1) begin
      $display("FAIL lat0_store_latency: got %0d want 1", lat); miscompares++;
    end
    op(1, 1'b0, 32'h0, 32'h0, 4'hF, 0, rd, e, lat, pr, er, ee, ek);
    vectors += 2;
    if (lat !== 1) begin
      $display("FAIL lat0_load_latency: got %0d want 1", lat); miscompares++;
    end
    if (rd !== 32'h0000000A) begin
      $display("FAIL lat0_load_rdata: got %h want 0000000a", rd); miscompares++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, er; logic e, ee; int lat; bit pr, ek;
    for (int u = 0; u < 2; u++) begin
      op(u, 1'b0, 32'h0, 32'h0, 4'hF, 5, rd, e, lat, pr, er, ee, ek);
      vectors += 2;
      if (pr !== 1'b1) begin
        $display("FAIL backpressure_hold u%0d: got %b want 1", u, pr); miscompares++;
      end
      if (rd !== er) begin
        $display("FAIL backpressure_rdata u%0d: got %h want %h", u, rd, er); miscompares++;
      end
    end
  endtask

  task automatic test_error();
    logic [31:0] rd, er; logic e, ee; int lat; bit pr, ek;
    op(0, 1'b0, 32'h13, 32'h0, 4'hF, 0, rd, e, lat, pr, er, ee, ek);
    vectors += 2;
    if (e !== ErrChk) begin
      $display("FAIL misaligned_err: got %b want %b", e, ErrChk); miscompares++;
    end
    if (rd !== (ErrChk ? 32'd0 : 32'h1234)) begin
      $display("FAIL misaligned_rdata: got %h want %h", rd, ErrChk ? 32'd0 : 32'h1234);
      miscompares++;
    end
    op(0, 1'b1, 32'h0, 32'h11111111, 4'hF, 0, rd, e, lat, pr, er, ee, ek);
    op(0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 0, rd, e, lat, pr, er, ee, ek);
    vectors++;
    if (e !== ErrChk) begin
      $display("FAIL range_err: got %b want %b", e, ErrChk); miscompares++;
    end
    op(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, rd, e, lat, pr, er, ee, ek);
    vectors++;
    if (rd !== (ErrChk ? 32'h11111111 : 32'hCAFEF00D)) begin
      $display("FAIL range_mem0: got %h want %h", rd, ErrChk ? 32'h11111111 : 32'hCAFEF00D);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, er; logic e, ee; int lat; bit pr, ek; int n;
    op(0, 1'b1, 32'h30, 32'h5A5A1234, 4'hF, 0, rd, e, lat, pr, er, ee, ek);
    issue(0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'hF);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    vectors += 2;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
      $display("FAIL wait_reset_state: got ready %b valid %b want 1 0", req_ready[0],
               resp_valid[0]);
      miscompares++;
    end
    op(0, 1'b0, 32'h30, 32'h0, 4'hF, 0, rd, e, lat, pr, er, ee, ek);
    if (rd !== 32'h5A5A1234) begin
      $display("FAIL wait_reset_nowrite: got %h want 5a5a1234", rd); miscompares++;
    end
    // Store commits, then reset drops the response; the write must remain.
    model_txn(0, 1'b1, 32'h34, 32'h00000077, 4'hF, er, ee, ek);
    issue(0, 1'b1, 32'h34, 32'h00000077, 4'hF);
    n = 0;
    while (resp_valid[0] !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors += 2;
    if (resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'd0) begin
      $display("FAIL resp_reset_drop: got valid %b rdata %h want 0 0", resp_valid[0],
               resp_rdata[0]);
      miscompares++;
    end
    @(negedge clk);
    reset = 1'b1;
    op(0, 1'b0, 32'h34, 32'h0, 4'hF, 0, rd, e, lat, pr, er, ee, ek);
    if (rd !== 32'h00000077) begin
      $display("FAIL resp_reset_keep: got %h want 00000077", rd); miscompares++;
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, er, addr, wd; logic e, ee, we; int lat; bit pr, ek;
    logic [3:0] be; int u; int r;
    for (int n = 0; n < 120; n++) begin
      u    = n % 2;
      we   = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 31)) << 2;
      r    = $urandom_range(0, 7);
      if (r == 0) addr = addr | 32'($urandom_range(1, 3));
      else if (r == 1) addr = (32'(Depth) + 32'($urandom_range(0, 31))) << 2;
      wd = $urandom;
      be = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      op(u, we, addr, wd, be, $urandom_range(0, 2), rd, e, lat, pr, er, ee, ek);
      vectors += 3;
      if (lat !== lat_of(u) + 1) begin
        $display("FAIL rand_latency n%0d: got %0d want %0d", n, lat, lat_of(u) + 1);
        miscompares++;
      end
      if (e !== ee || pr !== 1'b1) begin
        $display("FAIL rand_err n%0d: got err %b proto %b want %b 1", n, e, pr, ee);
        miscompares++;
      end
      if (ek && rd !== er) begin
        $display("FAIL rand_rdata n%0d addr %h: got %h want %h", n, addr, rd, er);
        miscompares++;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int u = 0; u < 2; u++) begin
      req_valid[u]  = 1'b0;
      req_we[u]     = 1'b0;
      req_addr[u]   = 32'd0;
      req_wdata[u]  = 32'd0;
      req_be[u]     = 4'd0;
      resp_ready[u] = 1'b0;
      for (int i = 0; i < Depth; i++) begin
        mdl[u][i]   = 32'd0;
        known[u][i] = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    test_load_basic();
    test_byte_enable();
    test_latency0();
    test_backpressure();
    test_error();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
